// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the control unit (master) and the
// memory responder (slave). The err line exists only when MEM_RESP_ERR_EN
// is defined.
interface mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req;
  logic              rd;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              ack;
  logic              busy;
`ifdef MEM_RESP_ERR_EN
  logic              err;

  modport master (output req, rd, we, address, dataIn,
                  input  dataOut, ack, busy, err);
  modport slave  (input  req, rd, we, address, dataIn,
                  output dataOut, ack, busy, err);
`else
  modport master (output req, rd, we, address, dataIn,
                  input  dataOut, ack, busy);
  modport slave  (input  req, rd, we, address, dataIn,
                  output dataOut, ack, busy);
`endif
endinterface

// File: rtl/mem_responder.sv
// Single-ported word store answering one read or write per four-phase
// req/ack handshake, with WAIT_STATES idle cycles before the access.
// Optional feature macro: MEM_RESP_ERR_EN (adds err; rd==we requests are
// rejected without an access). Without it, rd&we is a write and a request
// with neither qualifier is a no-op that is still acknowledged.
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  mem_responder_if.slave  bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_q;
  logic              we_q;
  logic [DATA_W-1:0] dout_q;
  logic              ack_q;
  logic              busy_q;
  logic              access;
  logic              do_write;
  logic              do_read;
  logic              bad_req;

  // Storage is deliberately left without reset so it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  // Access decode from the captured qualifiers; reads never win over writes.
`ifdef MEM_RESP_ERR_EN
  assign bad_req  = (rd_q == we_q);
  assign do_write = we_q & ~rd_q;
`else
  assign bad_req  = 1'b0;
  assign do_write = we_q;
`endif
  assign do_read = rd_q & ~we_q;
  assign access  = (state == BUSY) && (cnt == 4'd0);

  // Write port: fires on the last BUSY cycle; reset forces IDLE so an
  // aborted write never reaches the array.
  always_ff @(posedge clock) begin
    if (access && do_write) begin
      mem[addr_q] <= data_q;
    end
  end

  // Handshake FSM with registered ack/busy/err and read data.
`ifdef MEM_RESP_ERR_EN
  logic err_q;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= 1'b0;
      we_q   <= 1'b0;
      dout_q <= '0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q <= bus.address;
            data_q <= bus.dataIn;
            rd_q   <= bus.rd;
            we_q   <= bus.we;
            cnt    <= WAIT_LOAD;
            busy_q <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (do_read) begin
              dout_q <= mem[addr_q];
            end
            ack_q <= 1'b1;
`ifdef MEM_RESP_ERR_EN
            err_q <= bad_req;
`endif
            state <= ACK;
          end
        end
        ACK: begin
          if (!bus.req) begin
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            err_q  <= 1'b0;
`endif
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dataOut = dout_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
`ifdef MEM_RESP_ERR_EN
  assign bus.err     = err_q;
`else
  logic unused_bad;
  assign unused_bad = bad_req;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level model (word
// array plus the req->ack timeline) drives per-cycle expectations that a
// single compare process checks on every falling edge, plus literal checks
// for the directed scenarios. Honours MEM_RESP_ERR_EN when defined.
module tb_mem_responder;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference state: word array with written flags and expected outputs.
  logic [DW-1:0] mm [16];
  bit            mk [16];
  logic [DW-1:0] exp_dout = '0;
  bit            dout_known = 1'b1;
  logic          exp_ack = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_err = 1'b0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(bus.ack), 32'(exp_ack));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      if (dout_known) chk("dataOut", 32'(bus.dataOut), 32'(exp_dout));
`ifdef MEM_RESP_ERR_EN
      chk("err", 32'(bus.err), 32'(exp_err));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete handshake. Inputs are scrambled while the responder is
  // busy or acknowledging to prove they are ignored there.
  task automatic txn(input logic rd, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input int hold,
                     output logic [DW-1:0] dout_seen, output logic err_seen);
    bit wr, rdop, bad;
    bus.rd = rd; bus.we = we; bus.address = addr; bus.dataIn = data;
    bus.req = 1'b1;
    tick();                       // capture edge
    exp_busy = 1'b1; exp_ack = 1'b0;
    bus.address = AW'($urandom); bus.dataIn = DW'($urandom);
    bus.rd = 1'($urandom); bus.we = 1'($urandom);
    for (int k = 0; k < WS; k++) tick();
`ifdef MEM_RESP_ERR_EN
    bad = (rd == we);
    wr  = we && !rd;
`else
    bad = 1'b0;
    wr  = we;
`endif
    rdop = rd && !we;
    tick();                       // access edge: ack rises
    if (wr) begin mm[addr] = data; mk[addr] = 1'b1; end
    if (rdop) begin exp_dout = mm[addr]; dout_known = mk[addr]; end
    exp_ack = 1'b1; exp_err = bad;
    dout_seen = bus.dataOut;
`ifdef MEM_RESP_ERR_EN
    err_seen = bus.err;
`else
    err_seen = 1'b0;
`endif
    for (int k = 0; k < hold; k++) begin
      bus.address = AW'($urandom); bus.dataIn = DW'($urandom);
      tick();
    end
    bus.req = 1'b0;
    tick();
    exp_ack = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
  endtask

  logic [DW-1:0] d;
  logic          e;

  initial begin
    for (int i = 0; i < 16; i++) begin mm[i] = '0; mk[i] = 1'b0; end
    bus.req = 1'b0; bus.rd = 1'b0; bus.we = 1'b0; bus.address = '0; bus.dataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_dout", 32'(bus.dataOut), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Write 0xA5 to addr 3, checking the ack latency explicitly.
    bus.rd = 1'b0; bus.we = 1'b1; bus.address = 4'd3; bus.dataIn = 8'hA5; bus.req = 1'b1;
    tick();
    exp_busy = 1'b1;
    chk("lat_e0_ack", 32'(bus.ack), 32'd0);
    tick();
    chk("lat_e1_ack", 32'(bus.ack), 32'd0);
    tick();
    mm[3] = 8'hA5; mk[3] = 1'b1; exp_ack = 1'b1;
    chk("lat_e2_ack", 32'(bus.ack), 32'd1);
    chk("wr_dout_held", 32'(bus.dataOut), 32'h00);
    bus.req = 1'b0;
    tick();
    exp_ack = 1'b0; exp_busy = 1'b0;
    chk("drop_ack", 32'(bus.ack), 32'd0);
    chk("drop_busy", 32'(bus.busy), 32'd0);

    // Read it back; data persists after the handshake.
    txn(1'b1, 1'b0, 4'd3, 8'h00, 0, d, e);
    chk("rd3_at_ack", 32'(d), 32'hA5);
    tick();
    chk("rd3_after", 32'(bus.dataOut), 32'hA5);

    // Long hold with scrambled inputs: one access only, captured values used.
    txn(1'b0, 1'b1, 4'd5, 8'h77, 5, d, e);
    txn(1'b1, 1'b0, 4'd5, 8'h00, 0, d, e);
    chk("hold_rd5", 32'(d), 32'h77);

    // Fill every address, then read all back.
    for (int i = 1; i < 16; i++) txn(1'b0, 1'b1, AW'(i), DW'(8'h10 + i), 0, d, e);
    txn(1'b0, 1'b1, 4'd0, 8'hFF, 0, d, e);
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, 1'b0, AW'(i), 8'h00, 0, d, e);
      chk($sformatf("fill_rd%0d", i), 32'(d), (i == 0) ? 32'hFF : 32'(8'h10 + i));
    end

    // rd and we together.
    txn(1'b1, 1'b1, 4'd2, 8'h5A, 0, d, e);
`ifdef MEM_RESP_ERR_EN
    chk("both_err", 32'(e), 32'd1);
    txn(1'b1, 1'b0, 4'd2, 8'h00, 0, d, e);
    chk("both_rd2", 32'(d), 32'h12);
`else
    chk("both_err", 32'(e), 32'd0);
    txn(1'b1, 1'b0, 4'd2, 8'h00, 0, d, e);
    chk("both_rd2", 32'(d), 32'h5A);
`endif

    // Reset while the write to addr 7 is still pending.
    bus.rd = 1'b0; bus.we = 1'b1; bus.address = 4'd7; bus.dataIn = 8'h3C; bus.req = 1'b1;
    tick();
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(bus.ack), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_dout", 32'(bus.dataOut), 32'd0);
    bus.req = 1'b0;
    exp_ack = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_dout = '0; dout_known = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    txn(1'b1, 1'b0, 4'd7, 8'h00, 0, d, e);
    chk("abort_lost", 32'(d), 32'h17);
    txn(1'b0, 1'b1, 4'd7, 8'h00, 0, d, e);
    txn(1'b1, 1'b0, 4'd7, 8'h00, 0, d, e);
    chk("abort_rd7", 32'(d), 32'h00);

    // Randomised traffic against the model, with idle gaps.
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      txn(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
          int'($urandom_range(0, 3)), d, e);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
